// File: rtl/trace_arbiter.sv
// Merges per-stage trace records through per-source FIFOs into one valid/ready stream; 2-cycle src->out latency.
// Sources never stall: trace_ready low holds the output; pushes into a full, un-popped FIFO are dropped and counted.
module trace_arbiter #(
  parameter  int NUM_SRC    = 4,
  parameter  int REC_WIDTH  = 128,
  parameter  int FIFO_DEPTH = 4,
  localparam int SRC_W      = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1,
  localparam int PTR_W      = $clog2(FIFO_DEPTH)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_SRC-1:0]           src_valid,
  input  logic [NUM_SRC*REC_WIDTH-1:0] src_data,
  output logic                         trace_valid,
  output logic [REC_WIDTH-1:0]         trace_data,
  output logic [SRC_W-1:0]             trace_src,
  input  logic                         trace_ready,
  output logic [NUM_SRC-1:0]           overflow,
  input  logic                         overflow_clr,
  output logic [15:0]                  drop_count
);

  typedef enum logic {S_EMPTY = 1'b0, S_FULL = 1'b1} state_e;

  logic [REC_WIDTH-1:0] mem_q    [NUM_SRC][FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q [NUM_SRC];
  logic [PTR_W-1:0]     rd_ptr_q [NUM_SRC];
  logic [PTR_W:0]       lvl_q    [NUM_SRC];

  state_e               state_q;
  logic [REC_WIDTH-1:0] trace_data_q;
  logic [SRC_W-1:0]     trace_src_q;
  logic [SRC_W-1:0]     last_grant_q;
  logic [NUM_SRC-1:0]   overflow_q, overflow_d;
  logic [15:0]          drop_cnt_q, drop_cnt_d;

  logic [NUM_SRC-1:0]   nonempty, full, push, pop, drop;
  logic [SRC_W-1:0]     grant;
  logic                 found;
  logic                 load;
  int                   idx;
  logic [3:0]           n_drop;
  logic [16:0]          cnt_sum;

  always_comb begin
    grant  = last_grant_q;
    found  = 1'b0;
    idx    = 0;
    n_drop = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      nonempty[i] = (lvl_q[i] != '0);
      full[i]     = (lvl_q[i] == (PTR_W+1)'(FIFO_DEPTH));
    end
    // Round-robin: scan upward from the source after the last grant.
    for (int k = 1; k <= NUM_SRC; k++) begin
      idx = (int'(last_grant_q) + k) % NUM_SRC;
      if (!found && nonempty[idx]) begin
        grant = SRC_W'(idx);
        found = 1'b1;
      end
    end
    load = ((state_q == S_EMPTY) || trace_ready) && (|nonempty);
    for (int i = 0; i < NUM_SRC; i++) begin
      pop[i]  = load && (grant == SRC_W'(i));
      push[i] = src_valid[i] && !(full[i] && !pop[i]);
      drop[i] = src_valid[i] && full[i] && !pop[i];
      n_drop  = n_drop + 4'(drop[i]);
    end
    cnt_sum    = {1'b0, drop_cnt_q} + 17'(n_drop);
    drop_cnt_d = cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
    // A drop in the clearing cycle must survive the clear.
    overflow_d = (overflow_clr ? '0 : overflow_q) | drop;
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_SRC; i++) begin
      if (push[i]) mem_q[i][wr_ptr_q[i]] <= src_data[i*REC_WIDTH +: REC_WIDTH];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_EMPTY;
      trace_data_q <= '0;
      trace_src_q  <= '0;
      last_grant_q <= SRC_W'(NUM_SRC - 1);
      overflow_q   <= '0;
      drop_cnt_q   <= '0;
      for (int i = 0; i < NUM_SRC; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
        lvl_q[i]    <= '0;
      end
    end else begin
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
      for (int i = 0; i < NUM_SRC; i++) begin
        if (push[i]) wr_ptr_q[i] <= wr_ptr_q[i] + PTR_W'(1);
        if (pop[i])  rd_ptr_q[i] <= rd_ptr_q[i] + PTR_W'(1);
        lvl_q[i] <= lvl_q[i] + (PTR_W+1)'(push[i]) - (PTR_W+1)'(pop[i]);
      end
      if (load) begin
        trace_data_q <= mem_q[grant][rd_ptr_q[grant]];
        trace_src_q  <= grant;
        last_grant_q <= grant;
        state_q      <= S_FULL;
      end else if ((state_q == S_FULL) && trace_ready) begin
        state_q <= S_EMPTY;
      end
    end
  end

  assign trace_valid = (state_q == S_FULL);
  assign trace_data  = trace_data_q;
  assign trace_src   = trace_src_q;
  assign overflow    = overflow_q;
  assign drop_count  = drop_cnt_q;

endmodule

// File: tb/tb_trace_arbiter.sv
// Directed bench for trace_arbiter: expected records queued at stimulus time, compared as the sink accepts them.
module tb_trace_arbiter;
  localparam int NS = 4;
  localparam int RW = 128;

  logic            clk;
  logic            rst;
  logic [NS-1:0]   src_valid;
  logic [NS*RW-1:0] src_data;
  logic            trace_valid;
  logic [RW-1:0]   trace_data;
  logic [1:0]      trace_src;
  logic            trace_ready;
  logic [NS-1:0]   overflow;
  logic            overflow_clr;
  logic [15:0]     drop_count;

  typedef struct packed {
    logic [1:0]    src;
    logic [RW-1:0] data;
  } rec_t;

  rec_t sb_q[$];
  int   pass_cnt  = 0;
  int   total_cnt = 0;

  trace_arbiter #(.NUM_SRC(NS), .REC_WIDTH(RW), .FIFO_DEPTH(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .src_valid    (src_valid),
    .src_data     (src_data),
    .trace_valid  (trace_valid),
    .trace_data   (trace_data),
    .trace_src    (trace_src),
    .trace_ready  (trace_ready),
    .overflow     (overflow),
    .overflow_clr (overflow_clr),
    .drop_count   (drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
    total_cnt++;
    assert (obs === exp) begin
      pass_cnt++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int s, input logic [RW-1:0] d, input bit expect_out);
    src_valid[s] = 1'b1;
    src_data[s*RW +: RW] = d;
    if (expect_out) sb_q.push_back('{src: 2'(s), data: d});
  endtask

  task automatic do_reset;
    rst = 1'b0;
    sb_q.delete();
    tick;
    rst = 1'b1;
    tick;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 60 && sb_q.size() != 0; i++) tick;
    tick;
    tick;
    chk(tag, sb_q.size(), 0);
  endtask

  // Sink-side scoreboard: every accepted record must be the next expected one.
  always @(negedge clk) begin
    if (rst && trace_valid && trace_ready) begin
      chk("sb_expected", sb_q.size() != 0, 1'b1);
      if (sb_q.size() != 0) begin
        rec_t e;
        e = sb_q.pop_front();
        chk("sb_src", trace_src, e.src);
        chk("sb_data", trace_data, e.data);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst          = 1'b1;
    src_valid    = '0;
    src_data     = '0;
    trace_ready  = 1'b1;
    overflow_clr = 1'b0;
    #1 rst = 1'b0;
    #1;
    chk("rst_valid", trace_valid, 0);
    chk("rst_data", trace_data, 0);
    chk("rst_src", trace_src, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_drops", drop_count, 0);
    tick;
    tick;
    rst = 1'b1;
    tick;
    tick;

    // Single record on source 2: visible two cycles after the strobe, for one cycle.
    send(2, 128'hA5, 1'b1);
    tick;
    src_valid = '0;
    @(negedge clk);
    chk("single_c1_valid", trace_valid, 0);
    tick;
    @(negedge clk);
    chk("single_c2_valid", trace_valid, 1);
    chk("single_c2_src", trace_src, 2);
    chk("single_c2_data", trace_data, 128'hA5);
    tick;
    @(negedge clk);
    chk("single_c3_valid", trace_valid, 0);

    // Round robin from reset: all four push together, emerge 0,1,2,3 back to back.
    do_reset;
    for (int i = 0; i < NS; i++) send(i, 128'h100 + i, 1'b1);
    tick;
    src_valid = '0;
    tick;
    for (int k = 0; k < NS; k++) begin
      @(negedge clk);
      chk($sformatf("rr_valid%0d", k), trace_valid, 1);
      chk($sformatf("rr_src%0d", k), trace_src, k);
      tick;
    end
    @(negedge clk);
    chk("rr_idle", trace_valid, 0);

    // Backpressure: six records into src1 while the sink stalls; the sixth is dropped.
    trace_ready = 1'b0;
    for (int k = 0; k < 10; k++) begin
      src_valid = '0;
      if (k < 6) send(1, 128'h300 + k, k < 5);
      tick;
      @(negedge clk);
      if (k >= 1) begin
        chk($sformatf("bp_valid%0d", k), trace_valid, 1);
        chk($sformatf("bp_hold%0d", k), trace_data, 128'h300);
      end
    end
    src_valid = '0;
    chk("bp_ovf", overflow, 4'b0010);
    chk("bp_drops", drop_count, 1);
    tick;
    trace_ready = 1'b1;
    drain("bp_drain");

    // Full FIFO popped in the same cycle as a new push: accepted, no drop.
    overflow_clr = 1'b1;
    tick;
    overflow_clr = 1'b0;
    chk("fp_clr_ovf", overflow, 0);
    trace_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      src_valid = '0;
      send(0, 128'h400 + k, 1'b1);
      tick;
    end
    src_valid = '0;
    send(0, 128'h405, 1'b1);
    trace_ready = 1'b1;
    tick;
    src_valid = '0;
    chk("fp_ovf", overflow, 0);
    chk("fp_drops", drop_count, 1);
    drain("fp_drain");

    // Clear colliding with a new drop on src3: the new drop wins.
    trace_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      src_valid = '0;
      send(3, 128'h500 + k, 1'b1);
      tick;
    end
    src_valid = '0;
    send(3, 128'h5FF, 1'b0);
    overflow_clr = 1'b1;
    tick;
    src_valid    = '0;
    overflow_clr = 1'b0;
    chk("clr_drop_ovf", overflow, 4'b1000);
    chk("clr_drop_cnt", drop_count, 2);
    overflow_clr = 1'b1;
    tick;
    overflow_clr = 1'b0;
    chk("clr_only_ovf", overflow, 0);
    chk("clr_only_cnt", drop_count, 2);
    trace_ready = 1'b1;
    drain("clr_drain");

    // Reset mid-burst: buffered records vanish, src0 regains first priority.
    trace_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      src_valid = '0;
      send(2, 128'h600 + k, 1'b0);
      tick;
    end
    src_valid = '0;
    tick;
    @(negedge clk);
    chk("mb_valid_before", trace_valid, 1);
    tick;
    rst = 1'b0;
    sb_q.delete();
    #1;
    chk("mb_valid_async", trace_valid, 0);
    chk("mb_drops_async", drop_count, 0);
    tick;
    rst = 1'b1;
    trace_ready = 1'b1;
    for (int k = 0; k < 5; k++) tick;
    @(negedge clk);
    chk("mb_idle", trace_valid, 0);
    tick;
    send(0, 128'h700, 1'b1);
    send(3, 128'h703, 1'b1);
    tick;
    src_valid = '0;
    tick;
    @(negedge clk);
    chk("mb_first_valid", trace_valid, 1);
    chk("mb_first_src", trace_src, 0);
    drain("mb_drain");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/trace_arbiter.md
Name: trace_arbiter

Overview:
- Merges trace records from the per-stage trackers (IF, ID, EX, MEM, ...) into one serial trace stream for the trace sink.
- Trackers emit a one-cycle valid pulse and cannot be stalled, so each source gets a small FIFO.
- A round-robin scheduler drains the FIFOs into a single valid/ready output register.
- Overflow is counted as drops and flagged per source; nothing ever stalls the core.

Parameters:
- NUM_SRC, 4, number of tracker sources (2..8).
- REC_WIDTH, 128, width of one packed trace record; instantiate with $bits(ryuki_datatypes::trace_output).
- FIFO_DEPTH, 4, entries per source FIFO; power of two, at least 2.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- src_valid  in  NUM_SRC  per-source one-cycle record strobe; bit i = source i.
- src_data  in  NUM_SRC*REC_WIDTH  flattened records; source i at [i*REC_WIDTH +: REC_WIDTH].
- trace_valid  out  1  output record valid.
- trace_data  out  REC_WIDTH  output record.
- trace_src  out  $clog2(NUM_SRC)  index of the source that produced trace_data.
- trace_ready  in  1  sink accepts the record when trace_valid && trace_ready at a clock edge.
- overflow  out  NUM_SRC  sticky per-source drop flag.
- overflow_clr  in  1  synchronous clear of all overflow bits.
- drop_count  out  16  saturating total count of dropped records.

Behaviour:
- Reset (rst low, asynchronous, effective immediately):
  - trace_valid=0, trace_data=0, trace_src=0, overflow=0, drop_count=0.
  - All FIFO pointers and levels are 0; round-robin last-grant register = NUM_SRC-1, so source 0 has first priority.
  - Reset mid-transfer discards all buffered and in-flight records without emitting them.
- Source FIFOs:
  - push_i = src_valid[i] && !(full_i && !pop_i).
  - A full FIFO popped in the same cycle accepts the push without overflow.
  - A push on a full, un-popped FIFO drops the record, sets overflow[i] and increments drop_count (saturates at 16'hFFFF).
  - Multiple sources dropping in one cycle add the number of drops, still saturating.
  - No bypass: a push into an empty FIFO is not visible to the arbiter until the next cycle.
- Output register, two states:
  - EMPTY (trace_valid=0).
  - FULL (trace_valid=1).
  - load = (EMPTY || trace_ready) && any FIFO non-empty.
  - On load: pop the granted FIFO; trace_data and trace_src take its head; state becomes FULL.
  - FULL && trace_ready && no FIFO non-empty -> EMPTY.
  - FULL && !trace_ready: hold trace_data and trace_src stable; no pop.
  - Back-to-back: one record per cycle when trace_ready is held high; no bubble between records.
- Arbitration:
  - Grant the first non-empty source scanning from last_grant+1 upward, wrapping modulo NUM_SRC.
  - last_grant updates only on load.
  - Per-source order is preserved; cross-source order is arbitration order.
- Latency: src_valid in cycle c with all FIFOs empty and output EMPTY gives trace_valid in cycle c+2.
- overflow_clr clears all bits. A new drop in the same cycle wins, so that bit stays set. drop_count is not cleared by overflow_clr.
- src_valid on a source with no free entry never corrupts the stored entries.

Test Plan:
- Single record: reset, then src_valid[2]=1 with src_data slice 2=0xA5 in cycle 5, trace_ready=1 -> trace_valid=1 in cycle 7 only, trace_data=0xA5, trace_src=2.
- Round robin: all four sources push one record in the same cycle, trace_ready=1 -> output order src 0,1,2,3 on four consecutive cycles, then trace_valid=0.
- Backpressure: trace_ready=0 for 10 cycles while src1 pushes 6 records (FIFO_DEPTH=4) -> trace_data is stable throughout. After release, the first 5 records appear in order and the 6th is dropped; overflow=4'b0010, drop_count=1.
- Full plus pop: src0 FIFO full with output FULL, then trace_ready=1 in the same cycle as src_valid[0] -> no drop; overflow=0, and all 5 records plus the held one emerge in order.
- overflow_clr in the same cycle as a new drop on src3 -> overflow[3] stays 1. overflow_clr alone on the next cycle -> overflow=0, drop_count unchanged.
- Reset mid-burst: rst low for 1 cycle while 3 records are buffered and trace_valid=1 -> trace_valid=0 immediately and no old records appear after rst returns high. A new push emerges with trace_src matching its source, and src0 has first priority.
